// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped UART transmitter for the core's data bus. Stores to TXDATA
// push bytes into a TX FIFO; a baud counter plus a start/data/stop serializer
// shifts them out on `tx`, LSB first, 8N1.
//
// Register window (16 bytes at BASE_ADDR, offset = address[3:2]):
//   0x0 TXDATA  : write pushes dataOut[7:0]; reads 0
//   0x4 STATUS  : [0] busy, [1] full, [2] empty, [3] overflow (W1C),
//                 [11:8] FIFO count
//   0x8 BAUDDIV : [15:0] read/write, bit period = DIV+1 clocks
//   0xC reserved: reads 0, writes ignored
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-low
//   address      - core bus address
//   dataOut      - core write data
//   writeEnable  - core write strobe (one cycle per store)
//   readData     - combinational register read data, 0 when not selected
//   selected     - address falls inside this block's window
//   tx           - registered serial output, idles high
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dataOut,
    input  logic        writeEnable,
    output logic [31:0] readData,
    output logic        selected,
    output logic        tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       wr_strobe;
    logic       push_req;
    logic       ovf_clr;
    logic       div_wr;

    assign selected  = (address[31:4] == BASE_ADDR[31:4]);
    assign offset    = address[3:2];
    assign wr_strobe = writeEnable & selected;
    assign push_req  = wr_strobe && (offset == 2'd0);
    assign ovf_clr   = wr_strobe && (offset == 2'd1) && dataOut[3];
    assign div_wr    = wr_strobe && (offset == 2'd2);

    // Bits of the bus that this block never looks at.
    logic unused_bits;
    assign unused_bits = &{1'b0, address[1:0], dataOut[31:16]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          overflow_set;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // only refused when the serializer is not draining it this cycle.
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dataOut[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic        overflow;
    logic [15:0] baud_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (div_wr) begin
                baud_div <= dataOut[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_n;
    logic [15:0] baud_cnt;
    logic [15:0] baud_cnt_n;
    logic [7:0]  shift;
    logic [7:0]  shift_n;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_n;
    logic        tx_n;
    logic        bit_end;

    assign bit_end = (baud_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            tx       <= tx_n;
        end
    end

    // The counter reloads from baud_div only at a bit boundary, so a
    // BAUDDIV write never shortens or stretches the bit in flight.
    // `tx` is registered from the next-state values so the line changes on
    // the same edge as the state it belongs to.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_n    = mem[rd_ptr];
                    baud_cnt_n = baud_div;
                    state_n    = START;
                end
            end

            START: begin
                if (bit_end) begin
                    state_n    = DATA;
                    bit_idx_n  = '0;
                    baud_cnt_n = baud_div;
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = baud_div;
                    shift_n    = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_n    = mem[rd_ptr];
                        baud_cnt_n = baud_div;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux (side-effect free)
    // ------------------------------------------------------------------
    logic        busy;
    logic [31:0] status_word;

    assign busy = (state != IDLE) || !fifo_empty;

    always_comb begin
        status_word       = '0;
        status_word[0]    = busy;
        status_word[1]    = fifo_full;
        status_word[2]    = fifo_empty;
        status_word[3]    = overflow;
        status_word[11:8] = 4'(count);
    end

    always_comb begin
        readData = '0;
        if (selected) begin
            case (offset)
                2'd1:    readData = status_word;
                2'd2:    readData = {16'h0000, baud_div};
                default: readData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_mmio
//
// Self-checking bench for uart_tx_mmio. Expected serial waveforms are built
// from the 8N1 frame definition (start 0, data LSB first, stop 1, each bit
// DIV+1 clocks); expected STATUS words are assembled from the bench's own
// bookkeeping of bytes written and bytes in flight.
// ---------------------------------------------------------------------------
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_DIV = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] dataOut = '0;
    logic        writeEnable = 1'b0;
    logic [31:0] readData;
    logic        selected;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .dataOut     (dataOut),
        .writeEnable (writeEnable),
        .readData    (readData),
        .selected    (selected),
        .tx          (tx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_of(input bit busy, input bit full, input bit empty,
                                              input bit ovf, input int cnt);
        logic [31:0] w;
        w       = '0;
        w[0]    = busy;
        w[1]    = full;
        w[2]    = empty;
        w[3]    = ovf;
        w[11:8] = 4'(cnt);
        return w;
    endfunction

    // Bit i (0..9) of an 8N1 frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return d[i-1];
    endfunction

    // Bus tasks start and end on a falling edge; a write is sampled at the
    // rising edge in between.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        address     = addr;
        dataOut     = data;
        writeEnable = 1'b1;
        @(negedge clk);
        writeEnable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        address = addr;
        #1;
        data = readData;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got still running expected finish");
        $fatal(1);
    end

    logic [31:0] r;
    logic [7:0]  bytes [DEPTH+2];
    int          rnd_n;
    int          rnd_div;

    initial begin
        logic [7:0] d;
        logic [7:0] d2;
        logic       seen_low;

        // ---------------- reset state ----------------
        reset   = 1'b0;
        address = A_ST;
        repeat (3) @(negedge clk);
        check("tx_in_reset", tx, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        bus_read(A_ST, r);
        check("rst_status", r, status_of(0, 0, 1, 0, 0));
        bus_read(A_DIV, r);
        check("rst_div", r, 32'd433);
        bus_read(A_TX, r);
        check("txdata_reads_0", r, 0);
        bus_read(A_RSV, r);
        check("rsv_reads_0", r, 0);
        check("sel_in_window", selected, 1);
        bus_read(BASE + 32'h10, r);
        check("sel_above", selected, 0);
        check("rd_above", r, 0);
        bus_read(BASE - 32'h4, r);
        check("sel_below", selected, 0);

        // ---------------- BAUDDIV width, ignored writes ----------------
        @(negedge clk);
        bus_write(A_DIV, 32'hFFFF_1234);
        bus_read(A_DIV, r);
        check("div_16bit", r, 32'h0000_1234);
        bus_write(A_RSV, 32'h0000_00FF);
        bus_write(BASE + 32'h10, 32'h0000_0077);
        bus_read(A_ST, r);
        check("no_push_outside", r, status_of(0, 0, 1, 0, 0));
        bus_read(A_DIV, r);
        check("rsv_write_ignored", r, 32'h0000_1234);

        // ---------------- single byte, DIV=3 ----------------
        @(negedge clk);
        bus_write(A_DIV, 32'd3);
        d = 8'h55;
        bus_write(A_TX, {24'hABCDEF, d});
        check("sb_tx_pre", tx, 1);
        bus_read(A_ST, r);
        check("sb_count_at_write", r, status_of(1, 0, 0, 0, 1));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("sb_bit_clk%0d", k), tx, frame_bit(d, (k - 1) / 4));
            if (k == 1) begin
                bus_read(A_ST, r);
                check("sb_popped", r, status_of(1, 0, 1, 0, 0));
            end
            if (k == 40) begin
                bus_read(A_ST, r);
                check("sb_busy_last", r, status_of(1, 0, 1, 0, 0));
            end
        end
        @(negedge clk);
        check("sb_idle_tx", tx, 1);
        bus_read(A_ST, r);
        check("sb_idle_status", r, status_of(0, 0, 1, 0, 0));

        // ---------------- back-to-back, DIV=0 ----------------
        @(negedge clk);
        bus_write(A_DIV, 32'd0);
        d  = 8'hA5;
        d2 = 8'h3C;
        bus_write(A_TX, {24'h0, d});
        bus_write(A_TX, {24'h0, d2});
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("b2b_clk%0d", k), tx,
                  (k <= 10) ? frame_bit(d, k - 1) : frame_bit(d2, k - 11));
        end
        @(negedge clk);
        check("b2b_idle_tx", tx, 1);
        bus_read(A_ST, r);
        check("b2b_idle_status", r, status_of(0, 0, 1, 0, 0));

        // ---------------- overflow, DIV=1000 ----------------
        @(negedge clk);
        bus_write(A_DIV, 32'd1000);
        for (int i = 0; i < 10; i++) begin
            bus_write(A_TX, 32'(i));
        end
        // One byte sits in the shifter, the rest queue up to DEPTH.
        bus_read(A_ST, r);
        check("ovf_status", r, status_of(1, 1, 0, (10 - 1) > DEPTH, (10 - 1) > DEPTH ? DEPTH : 9));
        @(negedge clk);
        bus_write(A_ST, 32'h0000_0008);
        bus_read(A_ST, r);
        check("ovf_cleared", r, status_of(1, 1, 0, 0, DEPTH));
        @(negedge clk);
        do_reset();
        bus_read(A_ST, r);
        check("ovf_rst_status", r, status_of(0, 0, 1, 0, 0));

        // ---------------- full FIFO plus push on the pop edge ----------------
        @(negedge clk);
        bus_write(A_DIV, 32'd3);
        for (int i = 0; i < DEPTH + 1; i++) begin
            bytes[i] = 8'($urandom);
        end
        bytes[1] = 8'h00;
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus_write(A_TX, {24'h0, bytes[i]});
        end
        // Now at first-write edge + 8.5 clocks.
        bus_read(A_ST, r);
        check("fp_full", r, status_of(1, 1, 0, 0, DEPTH));
        repeat (32) @(negedge clk);
        check("fp_stop_bit", tx, 1);
        bus_write(A_TX, 32'h0000_00EE);
        check("fp_next_start", tx, 0);
        bus_read(A_ST, r);
        check("fp_push_on_pop", r, status_of(1, 1, 0, 0, DEPTH));

        // ---------------- asynchronous reset mid-frame ----------------
        repeat (6) @(negedge clk);
        check("mid_data_low", tx, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_tx_high", tx, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(A_ST, r);
        check("mid_rst_status", r, status_of(0, 0, 1, 0, 0));
        bus_read(A_DIV, r);
        check("mid_rst_div", r, 32'd433);
        seen_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        check("no_frame_after_rst", seen_low, 0);

        // ---------------- randomized traffic ----------------
        for (int round = 0; round < 4; round++) begin
            rnd_div = $urandom_range(0, 3);
            rnd_n   = $urandom_range(1, 6);
            for (int i = 0; i < rnd_n; i++) begin
                bytes[i] = 8'($urandom);
            end
            @(negedge clk);
            bus_write(A_DIV, 32'(rnd_div));
            fork
                begin : writer
                    for (int i = 0; i < rnd_n; i++) begin
                        repeat ($urandom_range(0, 12)) @(negedge clk);
                        bus_write(A_TX, {24'($urandom), bytes[i]});
                    end
                end
                begin : monitor
                    for (int f = 0; f < rnd_n; f++) begin
                        int          waited;
                        logic [9:0]  bits;
                        logic        bad;
                        logic [7:0]  got;
                        waited = 0;
                        do begin
                            @(negedge clk);
                            waited++;
                        end while (tx !== 1'b0 && waited < 3000);
                        if (tx !== 1'b0) begin
                            check("rnd_start_timeout", tx, 0);
                            break;
                        end
                        bad  = 1'b0;
                        bits = '0;
                        for (int b = 0; b < 10; b++) begin
                            for (int c = 0; c <= rnd_div; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (c == 0) bits[b] = tx;
                                else if (tx !== bits[b]) bad = 1'b1;
                            end
                        end
                        got = bits[8:1];
                        check($sformatf("rnd_r%0d_byte%0d", round, f), got, bytes[f]);
                        check($sformatf("rnd_r%0d_stop%0d", round, f), bits[9], 1);
                        check($sformatf("rnd_r%0d_bitlen%0d", round, f), bad, 0);
                    end
                end
            join
            @(negedge clk);
            bus_read(A_ST, r);
            check($sformatf("rnd_r%0d_idle", round), r, status_of(0, 0, 1, 0, 0));
            check($sformatf("rnd_r%0d_tx_idle", round), tx, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the RISC-V core's data bus, downstream of the processor's `address`/`dataOut`/`writeEnable` outputs. Store instructions push bytes into a TX FIFO. Load instructions return status and configuration on `readData`, which the system bus mux routes back to the core's `dataIn`. A baud-rate counter and a start/data/stop serializer FSM drive the serial `tx` line.

## Interface
- `BASE_ADDR`, default 32'h8000_0000. Base of the 16-byte register window; bits [3:0] must be zero.
- `FIFO_DEPTH`, default 8. TX FIFO depth; must be a power of 2, minimum 2.
- `DEFAULT_DIV`, default 16'd433. Baud divisor reset value. Bit period is DIV+1 clocks.
- `clk`, input, 1. Single clock, rising edge.
- `reset`, input, 1. Asynchronous, active-low.
- `address`, input, 32. Core bus address.
- `dataOut`, input, 32. Core write data.
- `writeEnable`, input, 1. Core write strobe. The core asserts it for exactly one cycle per store.
- `readData`, output, 32. Register read data. Combinational. 0 when `selected`=0.
- `selected`, output, 1. High when `address[31:4]` == `BASE_ADDR[31:4]`. Drives the bus mux.
- `tx`, output, 1. Serial output. Idles high.

## Operation
- Register map: offset = `address[3:2]`. Reads have no side effects.
  - Offset 0x0, TXDATA. Write pushes `dataOut[7:0]`. Reads return 0.
  - Offset 0x4, STATUS. Bit0 busy (FSM not IDLE or FIFO not empty). Bit1 full. Bit2 empty. Bit3 overflow (sticky). Bits[11:8] FIFO count. Other bits are 0. Writing 1 to bit3 clears overflow.
  - Offset 0x8, BAUDDIV. Bits [15:0] are read/write; upper bits read 0.
  - Offset 0xC is reserved. Reads return 0; writes are ignored.
- Push on TXDATA when full and no pop in the same cycle: byte dropped, overflow set to 1. If a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- Count width is log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. A baud counter loads DIV and decrements; `bitEnd` is when the counter = 0.
  - IDLE: `tx`=1. If FIFO is not empty: pop into an 8-bit shift register, load the counter, go to START.
  - START: `tx`=0. On `bitEnd`: go to DATA, bitIdx=0.
  - DATA: `tx`=shift[0], LSB first. On `bitEnd`: shift right and increment bitIdx. After bit 7, go to STOP.
  - STOP: `tx`=1. On `bitEnd`: if FIFO is not empty, pop and go directly to START (back-to-back frames); else go to IDLE.
- BAUDDIV writes update the register immediately. The counter uses the new value at its next load, i.e. the next bit boundary; the current bit is never truncated.
- BAUDDIV=0 is legal: each bit lasts 1 clock.
- Reset (asynchronous, mid-frame included): FSM to IDLE, `tx`=1 immediately, FIFO emptied, overflow=0, BAUDDIV=DEFAULT_DIV. The partial frame is abandoned.

## Timing
- Reset values: `tx`=1. STATUS=0x0000_0004 (empty only). `readData` reflects the address combinationally.
- A write is sampled at the rising edge E where `writeEnable`=1 and `selected`=1. FIFO count increments at E.
- From IDLE with an empty FIFO, a write at edge E produces the pop at E+1, and `tx` falls after E+1.
- Frame length is exactly 10×(DIV+1) clocks, start bit edge to the end of the stop bit.
- Back-to-back frames have zero idle clocks between the stop bit and the next start bit.
- `readData` and `selected` have zero-cycle latency from `address`. The core samples `readData` in the same cycle.
- Registered outputs: `tx`. There are no combinational paths from `dataOut` or `writeEnable` to any output.

## Test plan
- Reset then STATUS read: deassert `reset` → `tx`=1, STATUS=0x0000_0004, BAUDDIV reads 433.
- Single byte: BAUDDIV=3, write 0x55 to TXDATA → `tx` low 1 cycle after the write edge. Then 10 bits of 4 clocks each: 0,1,0,1,0,1,0,1,0,1. Then idle high. busy clears 41 clocks after the write.
- Back-to-back: BAUDDIV=0, write 0xA5 then 0x3C → 20 contiguous bit-clocks with no gap, decoding as 0xA5 then 0x3C.
- Overflow: BAUDDIV=1000, write 10 bytes rapidly → first byte popped into the shifter, 8 queued, 10th dropped. STATUS = full, busy, overflow, count 8 (0x0000_080B). Write 0x8 to STATUS → overflow clears.
- Full plus simultaneous pop: FIFO full, push on the STOP-to-START pop edge → push accepted, count stays 8, overflow stays 0.
- Reset mid-frame: assert `reset` during the DATA state with 3 bytes queued → `tx`=1 asynchronously, STATUS=0x0000_0004 after release, no further frame emitted.
